ram_arbiter: RTL and testbench

Shares the 16-bit split-bank data RAM between two requesters: port 0 (CPU data path) and port 1 (DMA/debug). Read and write channels are arbitrated independently onto the RAM's separate read and write ports. The block provides:

- per-channel ownership locking,
- starvation protection for the waiting port,
- address range checking,
- tagged return of the RAM's one-cycle registered read data.

It sits directly between the requesters and the `ram` instance.

---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// master: requesters plus the RAM model; slave: the arbiter.
interface ram_arbiter_if;
    logic        p0_rd_req,   p1_rd_req;
    logic [15:0] p0_rd_addr,  p1_rd_addr;
    logic        p0_rd_lock,  p1_rd_lock;
    logic        p0_rd_ready, p1_rd_ready;
    logic        p0_rd_valid, p1_rd_valid;
    logic [15:0] p0_rd_data,  p1_rd_data;
    logic        p0_rd_err,   p1_rd_err;
    logic        p0_wr_req,   p1_wr_req;
    logic [15:0] p0_wr_addr,  p1_wr_addr;
    logic [15:0] p0_wr_data,  p1_wr_data;
    logic [1:0]  p0_wr_be,    p1_wr_be;
    logic        p0_wr_lock,  p1_wr_lock;
    logic        p0_wr_ready, p1_wr_ready;
    logic        p0_wr_err,   p1_wr_err;
    logic [15:0] ram_rd_addr;
    logic [15:0] ram_rd_data;
    logic [15:0] ram_wr_addr;
    logic [15:0] ram_wr_data;
    logic [1:0]  ram_wr_en;

    modport master (
        output p0_rd_req, p1_rd_req, p0_rd_addr, p1_rd_addr, p0_rd_lock, p1_rd_lock,
        input  p0_rd_ready, p1_rd_ready, p0_rd_valid, p1_rd_valid,
        input  p0_rd_data, p1_rd_data, p0_rd_err, p1_rd_err,
        output p0_wr_req, p1_wr_req, p0_wr_addr, p1_wr_addr, p0_wr_data, p1_wr_data,
        output p0_wr_be, p1_wr_be, p0_wr_lock, p1_wr_lock,
        input  p0_wr_ready, p1_wr_ready, p0_wr_err, p1_wr_err,
        input  ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en,
        output ram_rd_data
    );

    modport slave (
        input  p0_rd_req, p1_rd_req, p0_rd_addr, p1_rd_addr, p0_rd_lock, p1_rd_lock,
        output p0_rd_ready, p1_rd_ready, p0_rd_valid, p1_rd_valid,
        output p0_rd_data, p1_rd_data, p0_rd_err, p1_rd_err,
        input  p0_wr_req, p1_wr_req, p0_wr_addr, p1_wr_addr, p0_wr_data, p1_wr_data,
        input  p0_wr_be, p1_wr_be, p0_wr_lock, p1_wr_lock,
        output p0_wr_ready, p1_wr_ready, p0_wr_err, p1_wr_err,
        output ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_en,
        input  ram_rd_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the split-bank data RAM, independent read/write channels.
// Define RAM_ARB_RR_EN for round-robin IDLE tie-break; default is fixed priority to port 0.
module ram_arb_chan #(
    parameter int MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic [7:0] MAXW = 8'(MAX_WAIT);

    state_t          state, state_nxt;
    logic [1:0][7:0] wait_cnt;
    logic [1:0]      starved;
    logic [1:0]      gnt_raw;
    logic            own, win;
`ifdef RAM_ARB_RR_EN
    logic            rr_ptr;  // port favoured at the next IDLE tie
`endif

    assign own = (state == OWN1);
    assign gnt = gnt_raw & {2{rst_n}};

    always_comb begin
        for (int i = 0; i < 2; i++) starved[i] = (wait_cnt[i] == MAXW);
    end

    always_comb begin
        gnt_raw   = '0;
        state_nxt = IDLE;
        win       = 1'b0;
        if (state != IDLE && lock[own]) begin
            // owner keeps the channel unless the other port has waited MAX_WAIT cycles
            if (req[~own] && starved[~own]) begin
                gnt_raw[~own] = 1'b1;
                state_nxt     = lock[~own] ? (own ? OWN0 : OWN1) : IDLE;
            end else begin
                gnt_raw[own] = req[own];
                state_nxt    = state;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) begin
                if (starved[0])      win = 1'b0;
                else if (starved[1]) win = 1'b1;
`ifdef RAM_ARB_RR_EN
                else                 win = rr_ptr;
`else
                else                 win = 1'b0;
`endif
            end else begin
                win = req[1];
            end
            gnt_raw[win] = 1'b1;
            state_nxt    = lock[win] ? (win ? OWN1 : OWN0) : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            for (int i = 0; i < 2; i++)
                wait_cnt[i] <= (req[i] && !gnt_raw[i]) ?
                               (starved[i] ? wait_cnt[i] : wait_cnt[i] + 8'd1) : 8'd0;
        end
    end

`ifdef RAM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              rr_ptr <= 1'b0;
        else if (gnt_raw != '0)  rr_ptr <= ~gnt_raw[1];
    end
`endif
endmodule

module ram_arbiter #(
    parameter logic [15:0] RAM_BASE = 16'h3c00,
    parameter logic [15:0] RAM_TOP  = 16'h3fff,
    parameter int          MAX_WAIT = 8
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);
    logic [1:0]       rd_req, rd_lock, rd_gnt, wr_req, wr_lock, wr_gnt;
    logic [1:0][15:0] rd_addr, wr_addr, wr_data;
    logic [1:0][1:0]  wr_be;
    logic [1:0]       rd_vld, rd_err, wr_err_q;
    logic [1:0][15:0] rd_dat;
    logic             rd_sel, rd_acc, rd_ok, wr_sel, wr_acc, wr_ok;
    logic [15:0]      rd_a, wr_a, rd_addr_q;
    logic [1:0]       be;
    logic             tag_vld, tag_port, tag_err;

    function automatic logic in_rng(input logic [16:0] a);
        return (a >= {1'b0, RAM_BASE}) && (a <= {1'b0, RAM_TOP});
    endfunction

    assign rd_req  = {bus.p1_rd_req,  bus.p0_rd_req};
    assign rd_lock = {bus.p1_rd_lock, bus.p0_rd_lock};
    assign rd_addr = {bus.p1_rd_addr, bus.p0_rd_addr};
    assign wr_req  = {bus.p1_wr_req,  bus.p0_wr_req};
    assign wr_lock = {bus.p1_wr_lock, bus.p0_wr_lock};
    assign wr_addr = {bus.p1_wr_addr, bus.p0_wr_addr};
    assign wr_data = {bus.p1_wr_data, bus.p0_wr_data};
    assign wr_be   = {bus.p1_wr_be,   bus.p0_wr_be};

    ram_arb_chan #(.MAX_WAIT(MAX_WAIT)) u_rd (
        .clk(clk), .rst_n(rst_n), .req(rd_req), .lock(rd_lock), .gnt(rd_gnt));
    ram_arb_chan #(.MAX_WAIT(MAX_WAIT)) u_wr (
        .clk(clk), .rst_n(rst_n), .req(wr_req), .lock(wr_lock), .gnt(wr_gnt));

    // read path: address out now, tag returns with the RAM's registered data
    assign rd_sel = rd_gnt[1];
    assign rd_acc = |rd_gnt;
    assign rd_a   = rd_addr[rd_sel];
    assign rd_ok  = ({1'b0, rd_a} >= {1'b0, RAM_BASE}) &&
                    ({1'b0, rd_a} + 17'd1 <= {1'b0, RAM_TOP});
    assign bus.ram_rd_addr = rd_acc ? rd_a : rd_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            tag_vld   <= 1'b0;
            tag_port  <= 1'b0;
            tag_err   <= 1'b0;
        end else begin
            if (rd_acc) rd_addr_q <= rd_a;
            tag_vld  <= rd_acc;
            tag_port <= rd_sel;
            tag_err  <= rd_acc && !rd_ok;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign rd_vld[i] = tag_vld && (tag_port == 1'(i));
        assign rd_err[i] = rd_vld[i] && tag_err;
        assign rd_dat[i] = (rd_vld[i] && !tag_err) ? bus.ram_rd_data : 16'h0;
    end

    // write path: out-of-range bytes suppress the whole write
    assign wr_sel = wr_gnt[1];
    assign wr_acc = |wr_gnt;
    assign wr_a   = wr_addr[wr_sel];
    assign be     = wr_be[wr_sel];
    assign wr_ok  = (!be[0] || in_rng({1'b0, wr_a})) &&
                    (!be[1] || in_rng({1'b0, wr_a} + 17'd1));
    assign bus.ram_wr_en   = (wr_acc && wr_ok) ? be : 2'b00;
    assign bus.ram_wr_addr = wr_acc ? wr_a : 16'h0;
    assign bus.ram_wr_data = wr_acc ? wr_data[wr_sel] : 16'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err_q <= '0;
        else        wr_err_q <= wr_gnt & {2{!wr_ok}};
    end

    assign bus.p0_rd_ready = rd_gnt[0];
    assign bus.p1_rd_ready = rd_gnt[1];
    assign bus.p0_rd_valid = rd_vld[0];
    assign bus.p1_rd_valid = rd_vld[1];
    assign bus.p0_rd_data  = rd_dat[0];
    assign bus.p1_rd_data  = rd_dat[1];
    assign bus.p0_rd_err   = rd_err[0];
    assign bus.p1_rd_err   = rd_err[1];
    assign bus.p0_wr_ready = wr_gnt[0];
    assign bus.p1_wr_ready = wr_gnt[1];
    assign bus.p0_wr_err   = wr_err_q[0];
    assign bus.p1_wr_err   = wr_err_q[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed RAM model (registered read, write forwarding).
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    logic [7:0] mem [0:65535];

    ram_arbiter_if bus ();
    ram_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_byte(input logic [15:0] a);
        if (bus.ram_wr_en[0] && bus.ram_wr_addr == a)          return bus.ram_wr_data[7:0];
        if (bus.ram_wr_en[1] && bus.ram_wr_addr + 16'd1 == a)  return bus.ram_wr_data[15:8];
        return mem[a];
    endfunction

    always @(posedge clk) begin
        if (bus.ram_wr_en[0]) mem[bus.ram_wr_addr] <= bus.ram_wr_data[7:0];
        if (bus.ram_wr_en[1]) mem[bus.ram_wr_addr + 16'd1] <= bus.ram_wr_data[15:8];
        bus.ram_rd_data <= {rd_byte(bus.ram_rd_addr + 16'd1), rd_byte(bus.ram_rd_addr)};
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_in();
        bus.p0_rd_req = 0; bus.p0_rd_addr = 0; bus.p0_rd_lock = 0;
        bus.p1_rd_req = 0; bus.p1_rd_addr = 0; bus.p1_rd_lock = 0;
        bus.p0_wr_req = 0; bus.p0_wr_addr = 0; bus.p0_wr_data = 0; bus.p0_wr_be = 0; bus.p0_wr_lock = 0;
        bus.p1_wr_req = 0; bus.p1_wr_addr = 0; bus.p1_wr_data = 0; bus.p1_wr_be = 0; bus.p1_wr_lock = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; clear_in();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; clear_in();
        bus.p0_rd_req = 1; bus.p0_rd_addr = 16'h3c10;
        bus.p0_wr_req = 1; bus.p0_wr_addr = 16'h3c10; bus.p0_wr_be = 2'b11; bus.p0_wr_data = 16'h5555;
        #3;
        total++; if (bus.p0_rd_ready !== 1'b0) $display("FAIL reset_rd_ready: got %b exp 0", bus.p0_rd_ready); else passed++;
        total++; if (bus.p0_wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b exp 0", bus.p0_wr_ready); else passed++;
        total++; if (bus.ram_wr_en !== 2'b00) $display("FAIL reset_wr_en: got %b exp 00", bus.ram_wr_en); else passed++;
        total++; if (bus.ram_rd_addr !== 16'h0) $display("FAIL reset_rd_addr: got %h exp 0000", bus.ram_rd_addr); else passed++;
        total++; if (bus.ram_wr_addr !== 16'h0 || bus.ram_wr_data !== 16'h0)
            $display("FAIL reset_wr_bus: got %h/%h exp 0000/0000", bus.ram_wr_addr, bus.ram_wr_data); else passed++;
        total++; if ({bus.p0_rd_valid, bus.p1_rd_valid, bus.p0_rd_err, bus.p0_wr_err, bus.p1_wr_err} !== 5'b0)
            $display("FAIL reset_flags: got %b exp 00000",
                     {bus.p0_rd_valid, bus.p1_rd_valid, bus.p0_rd_err, bus.p0_wr_err, bus.p1_wr_err}); else passed++;
        clear_in();
    endtask

    task automatic test_single();
        do_reset();
        bus.p0_wr_req = 1; bus.p0_wr_addr = 16'h3c10; bus.p0_wr_data = 16'hbeef; bus.p0_wr_be = 2'b11;
        #1;
        total++; if (bus.p0_wr_ready !== 1'b1) $display("FAIL single_wr_ready: got %b exp 1", bus.p0_wr_ready); else passed++;
        total++; if (bus.ram_wr_en !== 2'b11 || bus.ram_wr_addr !== 16'h3c10 || bus.ram_wr_data !== 16'hbeef)
            $display("FAIL single_wr_bus: got %b/%h/%h exp 11/3c10/beef", bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data); else passed++;
        tick(); clear_in();
        bus.p0_rd_req = 1; bus.p0_rd_addr = 16'h3c10;
        #1;
        total++; if (bus.p0_rd_ready !== 1'b1 || bus.ram_rd_addr !== 16'h3c10)
            $display("FAIL single_rd_accept: got %b/%h exp 1/3c10", bus.p0_rd_ready, bus.ram_rd_addr); else passed++;
        tick(); clear_in(); #1;
        total++; if (bus.p0_rd_valid !== 1'b1 || bus.p0_rd_data !== 16'hbeef || bus.p0_rd_err !== 1'b0)
            $display("FAIL single_rd_return: got v%b d%h e%b exp v1 dbeef e0", bus.p0_rd_valid, bus.p0_rd_data, bus.p0_rd_err); else passed++;
        total++; if (bus.p1_rd_valid !== 1'b0 || bus.ram_rd_addr !== 16'h3c10)
            $display("FAIL single_rd_hold: got v%b a%h exp v0 a3c10", bus.p1_rd_valid, bus.ram_rd_addr); else passed++;
        tick();
        total++; if (bus.p0_rd_valid !== 1'b0 || bus.p0_rd_data !== 16'h0)
            $display("FAIL single_rd_oneshot: got v%b d%h exp v0 d0000", bus.p0_rd_valid, bus.p0_rd_data); else passed++;
    endtask

    task automatic test_odd_byte();
        do_reset();
        bus.p1_wr_req = 1; bus.p1_wr_addr = 16'h3c11; bus.p1_wr_data = 16'h1234; bus.p1_wr_be = 2'b01;
        #1;
        total++; if (bus.p1_wr_ready !== 1'b1 || bus.ram_wr_en !== 2'b01)
            $display("FAIL odd_wr: got r%b en%b exp r1 en01", bus.p1_wr_ready, bus.ram_wr_en); else passed++;
        tick(); clear_in();
        bus.p1_rd_req = 1; bus.p1_rd_addr = 16'h3c10;
        #1;
        total++; if (bus.p1_rd_ready !== 1'b1) $display("FAIL odd_rd_ready: got %b exp 1", bus.p1_rd_ready); else passed++;
        tick(); clear_in(); #1;
        total++; if (bus.p1_rd_valid !== 1'b1 || bus.p1_rd_data !== 16'h34ef)
            $display("FAIL odd_rd_return: got v%b d%h exp v1 d34ef", bus.p1_rd_valid, bus.p1_rd_data); else passed++;
    endtask

    task automatic test_contention();
        logic [11:0] pat;
`ifdef RAM_ARB_RR_EN
        pat = 12'h555;
`else
        pat = 12'heff;
`endif
        do_reset();
        bus.p0_rd_req = 1; bus.p0_rd_addr = 16'h3c10;
        bus.p1_rd_req = 1; bus.p1_rd_addr = 16'h3c12;
        for (int k = 0; k < 12; k++) begin
            #1;
            total++; if (bus.p0_rd_ready !== pat[k] || bus.p1_rd_ready !== !pat[k])
                $display("FAIL contend_grant[%0d]: got %b%b exp %b%b", k, bus.p1_rd_ready, bus.p0_rd_ready, !pat[k], pat[k]); else passed++;
            if (k > 0) begin
                total++; if (bus.p0_rd_valid !== pat[k-1] || bus.p1_rd_valid !== !pat[k-1])
                    $display("FAIL contend_valid[%0d]: got %b%b exp %b%b", k, bus.p1_rd_valid, bus.p0_rd_valid, !pat[k-1], pat[k-1]); else passed++;
                if (pat[k-1]) begin
                    total++; if (bus.p0_rd_data !== 16'h34ef)
                        $display("FAIL contend_data[%0d]: got %h exp 34ef", k, bus.p0_rd_data); else passed++;
                end
            end
            tick();
        end
        clear_in();
    endtask

    task automatic test_lock_starve();
        do_reset();
        bus.p0_wr_req = 1; bus.p0_wr_lock = 1; bus.p0_wr_addr = 16'h3c20; bus.p0_wr_data = 16'h1111; bus.p0_wr_be = 2'b11;
        bus.p1_wr_req = 1; bus.p1_wr_lock = 0; bus.p1_wr_addr = 16'h3c22; bus.p1_wr_data = 16'h2222; bus.p1_wr_be = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
            total++; if (bus.p0_wr_ready !== 1'b1 || bus.p1_wr_ready !== 1'b0)
                $display("FAIL lock_hold[%0d]: got %b%b exp 01", k, bus.p1_wr_ready, bus.p0_wr_ready); else passed++;
            tick();
        end
        #1;
        total++; if (bus.p1_wr_ready !== 1'b1 || bus.p0_wr_ready !== 1'b0 || bus.ram_wr_addr !== 16'h3c22)
            $display("FAIL starve_override: got %b%b a%h exp 10 a3c22", bus.p1_wr_ready, bus.p0_wr_ready, bus.ram_wr_addr); else passed++;
        tick();
        bus.p0_wr_req = 0;
        #1;
        total++; if (bus.p1_wr_ready !== 1'b1)
            $display("FAIL starve_to_idle: got %b exp 1", bus.p1_wr_ready); else passed++;
        tick(); clear_in();
    endtask

    task automatic test_range();
        do_reset();
        bus.p0_rd_req = 1; bus.p0_rd_addr = 16'h3fff;
        #1;
        total++; if (bus.p0_rd_ready !== 1'b1) $display("FAIL rng_rd_accept: got %b exp 1", bus.p0_rd_ready); else passed++;
        tick(); clear_in(); #1;
        total++; if (bus.p0_rd_valid !== 1'b1 || bus.p0_rd_err !== 1'b1 || bus.p0_rd_data !== 16'h0)
            $display("FAIL rng_rd_top: got v%b e%b d%h exp v1 e1 d0000", bus.p0_rd_valid, bus.p0_rd_err, bus.p0_rd_data); else passed++;
        bus.p0_rd_req = 1; bus.p0_rd_addr = 16'h3ffe;
        tick(); clear_in(); #1;
        total++; if (bus.p0_rd_valid !== 1'b1 || bus.p0_rd_err !== 1'b0)
            $display("FAIL rng_rd_edge: got v%b e%b exp v1 e0", bus.p0_rd_valid, bus.p0_rd_err); else passed++;
        bus.p0_rd_req = 1; bus.p0_rd_addr = 16'h3bff;
        tick(); clear_in(); #1;
        total++; if (bus.p0_rd_valid !== 1'b1 || bus.p0_rd_err !== 1'b1)
            $display("FAIL rng_rd_low: got v%b e%b exp v1 e1", bus.p0_rd_valid, bus.p0_rd_err); else passed++;
        bus.p0_wr_req = 1; bus.p0_wr_addr = 16'h3bff; bus.p0_wr_data = 16'habcd; bus.p0_wr_be = 2'b10;
        #1;
        total++; if (bus.ram_wr_en !== 2'b10 || bus.p0_wr_ready !== 1'b1)
            $display("FAIL rng_wr_hi: got en%b r%b exp en10 r1", bus.ram_wr_en, bus.p0_wr_ready); else passed++;
        tick(); clear_in(); #1;
        total++; if (bus.p0_wr_err !== 1'b0) $display("FAIL rng_wr_hi_err: got %b exp 0", bus.p0_wr_err); else passed++;
        bus.p0_wr_req = 1; bus.p0_wr_addr = 16'h3bff; bus.p0_wr_data = 16'habcd; bus.p0_wr_be = 2'b01;
        #1;
        total++; if (bus.ram_wr_en !== 2'b00 || bus.p0_wr_ready !== 1'b1)
            $display("FAIL rng_wr_lo: got en%b r%b exp en00 r1", bus.ram_wr_en, bus.p0_wr_ready); else passed++;
        tick(); clear_in(); #1;
        total++; if (bus.p0_wr_err !== 1'b1) $display("FAIL rng_wr_err_pulse: got %b exp 1", bus.p0_wr_err); else passed++;
        bus.p0_wr_req = 1; bus.p0_wr_addr = 16'h3c10; bus.p0_wr_be = 2'b00;
        #1;
        total++; if (bus.ram_wr_en !== 2'b00 || bus.p0_wr_ready !== 1'b1)
            $display("FAIL rng_wr_be0: got en%b r%b exp en00 r1", bus.ram_wr_en, bus.p0_wr_ready); else passed++;
        tick(); clear_in(); #1;
        total++; if (bus.p0_wr_err !== 1'b0) $display("FAIL rng_wr_err_clear: got %b exp 0", bus.p0_wr_err); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.p0_wr_req = 1; bus.p0_wr_lock = 1; bus.p0_wr_addr = 16'h3c30; bus.p0_wr_be = 2'b11; bus.p0_wr_data = 16'h7777;
        bus.p0_rd_req = 1; bus.p0_rd_addr = 16'h3c10;
        #1;
        total++; if (bus.p0_rd_ready !== 1'b1 || bus.p0_wr_ready !== 1'b1)
            $display("FAIL mid_accept: got %b%b exp 11", bus.p0_rd_ready, bus.p0_wr_ready); else passed++;
        tick();
        bus.p0_wr_req = 0; bus.p0_rd_req = 0;
        rst_n = 0;
        #1;
        total++; if (bus.p0_rd_valid !== 1'b0 || bus.p0_rd_err !== 1'b0)
            $display("FAIL mid_no_return: got v%b e%b exp v0 e0", bus.p0_rd_valid, bus.p0_rd_err); else passed++;
        @(posedge clk); #1;
        rst_n = 1;
        bus.p1_wr_req = 1; bus.p1_wr_addr = 16'h3c32; bus.p1_wr_be = 2'b11; bus.p1_wr_data = 16'h8888;
        #1;
        total++; if (bus.p1_wr_ready !== 1'b1 || bus.p0_rd_valid !== 1'b0)
            $display("FAIL mid_idle_grant: got r%b v%b exp r1 v0", bus.p1_wr_ready, bus.p0_rd_valid); else passed++;
        tick(); clear_in();
    endtask

    initial begin
        clear_in();
        test_reset();
        test_single();
        test_odd_byte();
        test_contention();
        test_lock_starve();
        test_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
